if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Holds the fetch PC, selects the
//                next PC and owns the IF/ID pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] imm32_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_data_d,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] ir_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        pc_err
);

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_PC_LO    = 32'h0000_3000;
    localparam logic [31:0] c_PC_HI    = 32'h0000_6FFC;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;

    localparam logic [1:0] c_NPC_SEQ    = 2'b00;
    localparam logic [1:0] c_NPC_BRANCH = 2'b01;
    localparam logic [1:0] c_NPC_JUMP   = 2'b10;
    localparam logic [1:0] c_NPC_JR     = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] r_ir_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic        r_valid_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_d_plus4;
    logic [1:0]  w_eff_op;
    logic [31:0] w_npc;
    logic        w_pc_err;

    always_comb begin
        w_pc_plus4   = r_pc + 32'd4;
        w_pc_d_plus4 = r_pc_d + 32'd4;
        // A bubble in D carries no real control flow, so it never redirects.
        w_eff_op     = r_valid_d ? npc_op : c_NPC_SEQ;
        w_npc        = w_pc_plus4;
        case (w_eff_op)
            c_NPC_SEQ:    w_npc = w_pc_plus4;
            c_NPC_BRANCH: w_npc = branch_taken ? (w_pc_d_plus4 + (imm32_d << 2)) : w_pc_plus4;
            c_NPC_JUMP:   w_npc = {w_pc_d_plus4[31:28], index26_d, 2'b00};
            c_NPC_JR:     w_npc = rs_data_d;
            default:      w_npc = w_pc_plus4;
        endcase
        w_pc_err = (r_pc[1:0] != 2'b00) || (r_pc < c_PC_LO) || (r_pc > c_PC_HI);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= c_RESET_PC;
            r_ir_d    <= c_NOP;
            r_pc_d    <= 32'd0;
            r_pc8_d   <= 32'd0;
            r_valid_d <= 1'b0;
        end else if (!stall) begin
            r_pc      <= w_npc;
            // A bad fetch address turns into a nop bubble but the PC keeps moving.
            r_ir_d    <= w_pc_err ? c_NOP : im_instr;
            r_pc_d    <= r_pc;
            r_pc8_d   <= r_pc + 32'd8;
            r_valid_d <= ~w_pc_err;
        end
    end

    assign im_addr = r_pc;
    assign ir_d    = r_ir_d;
    assign pc_d    = r_pc_d;
    assign pc8_d   = r_pc8_d;
    assign valid_d = r_valid_d;
    assign pc_err  = w_pc_err;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [31:0] imm32_d;
    logic [25:0] index26_d;
    logic [31:0] rs_data_d;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        pc_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_fpc, m_ir, m_pc, m_pc8;
    logic        m_valid;

    if_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .imm32_d      (imm32_d),
        .index26_d    (index26_d),
        .rs_data_d    (rs_data_d),
        .im_instr     (im_instr),
        .im_addr      (im_addr),
        .ir_d         (ir_d),
        .pc_d         (pc_d),
        .pc8_d        (pc8_d),
        .valid_d      (valid_d),
        .pc_err       (pc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign im_instr = imem(im_addr);

    function automatic logic m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".im_addr"}, im_addr, m_fpc);
        chk({tag, ".ir_d"},    ir_d,    m_ir);
        chk({tag, ".pc_d"},    pc_d,    m_pc);
        chk({tag, ".pc8_d"},   pc8_d,   m_pc8);
        chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_valid});
        chk({tag, ".pc_err"},  {31'd0, pc_err},  {31'd0, m_err(m_fpc)});
    endtask

    task automatic model_reset();
        m_fpc = 32'h3000; m_ir = 0; m_pc = 0; m_pc8 = 0; m_valid = 0;
    endtask

    // One clock edge with the given inputs; called at posedge+1, returns at posedge+1.
    task automatic step(input logic s, input logic [1:0] op, input logic bt,
                        input logic [31:0] imm, input logic [25:0] idx,
                        input logic [31:0] rs, input string tag);
        logic [31:0] tgt;
        logic [1:0]  eff;
        stall = s; npc_op = op; branch_taken = bt;
        imm32_d = imm; index26_d = idx; rs_data_d = rs;
        eff = m_valid ? op : 2'd0;
        case (eff)
            2'd1:    tgt = bt ? (m_pc + 4 + imm * 4) : (m_fpc + 4);
            2'd2:    tgt = ((m_pc + 4) & 32'hF000_0000) | ({6'd0, idx} * 4);
            2'd3:    tgt = rs;
            default: tgt = m_fpc + 4;
        endcase
        @(posedge clk);
        if (!s) begin
            m_ir    = m_err(m_fpc) ? 32'd0 : imem(m_fpc);
            m_valid = !m_err(m_fpc);
            m_pc    = m_fpc;
            m_pc8   = m_fpc + 8;
            m_fpc   = tgt;
        end
        #1;
        check_all(tag);
    endtask

    task automatic seq(input string tag);
        step(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] h_pc, h_ir, h_pcd;
        reset_n = 1'b0; stall = 1'b0; npc_op = 2'd0; branch_taken = 1'b0;
        imm32_d = 0; index26_d = 0; rs_data_d = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Sequential fetch after reset
        seq("seq1"); seq("seq2"); seq("seq3");
        chk("seq.fpc",  im_addr, 32'h300C);
        chk("seq.pcd",  pc_d,    32'h3008);
        chk("seq.pc8d", pc8_d,   32'h3010);
        seq("seq4"); seq("seq5");

        // Taken backward branch with delay slot
        chk("br.pcd_pre", pc_d, 32'h3010);
        step(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFC, 26'd0, 32'd0, "br");
        chk("br.fpc", im_addr, 32'h3004);
        chk("br.slot", ir_d, imem(32'h3014));

        // Jump and jr
        step(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h3000, "jr0");
        seq("seqj");
        chk("j.pcd_pre", pc_d, 32'h3000);
        step(1'b0, 2'd2, 1'b0, 32'd0, 26'h0000C40, 32'd0, "jump");
        chk("j.fpc", im_addr, 32'h3100);
        step(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h3200, "jr");
        chk("jr.fpc", im_addr, 32'h3200);

        // Stall across a taken branch
        h_pc = im_addr; h_ir = ir_d; h_pcd = pc_d;
        step(1'b1, 2'd1, 1'b1, 32'd8, 26'd0, 32'd0, "stall1");
        step(1'b1, 2'd1, 1'b1, 32'd8, 26'd0, 32'd0, "stall2");
        chk("stall.fpc", im_addr, h_pc);
        chk("stall.ir",  ir_d,    h_ir);
        chk("stall.pcd", pc_d,    h_pcd);
        step(1'b0, 2'd1, 1'b1, 32'd8, 26'd0, 32'd0, "unstall");
        chk("unstall.fpc", im_addr, h_pcd + 32'd4 + 32'd32);

        // Misaligned jr target
        step(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h3002, "jrbad");
        chk("jrbad.err", {31'd0, pc_err}, 32'd1);
        seq("bubble");
        chk("bubble.ir",    ir_d, 32'd0);
        chk("bubble.valid", {31'd0, valid_d}, 32'd0);
        step(1'b0, 2'd1, 1'b1, 32'h0000_0100, 26'd0, 32'd0, "bubbr");
        chk("bubbr.fpc", im_addr, 32'h300A);

        // Range boundaries
        do_reset("rst_a");
        seq("b1");
        step(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h6FFC, "hi_in");
        chk("hi_in.err", {31'd0, pc_err}, 32'd0);
        seq("hi_out");
        chk("hi_out.err", {31'd0, pc_err}, 32'd1);
        do_reset("rst_b");
        seq("b2");
        step(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h2FFC, "lo_out");
        chk("lo_out.err", {31'd0, pc_err}, 32'd1);

        // Asynchronous reset between edges at F_PC=0x3040
        do_reset("rst_c");
        repeat (16) seq("run");
        chk("pre_async.fpc", im_addr, 32'h3040);
        do_reset("async");
        chk("async.fpc", im_addr, 32'h3000);
        seq("resume");
        chk("resume.fpc", im_addr, 32'h3004);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rs;
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_rst");
            end else begin
                rs = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
                if ($urandom_range(0, 7) == 0) rs = rs + $urandom_range(1, 3);
                step(($urandom_range(0, 3) == 0),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     32'($signed($urandom_range(0, 63)) - 32),
                     26'($urandom_range(32'h0C00, 32'h1BFF)),
                     rs, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
